// File: rtl/vga_pattern_ctrl.sv
// Test-pattern scheduler and registered RGB565 pixel source.
// Patterns change only at a frame boundary, and one black frame is inserted between patterns.
module vga_pattern_ctrl #(
  parameter int H_VALID    = 640,
  parameter int V_VALID    = 480,
  parameter int FRAME_HOLD = 120,
  parameter int MODE_NUM   = 6
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic        key_flag,
  input  logic        auto_en,
  output logic [15:0] pix_data,
  output logic [2:0]  pat_mode,
  output logic        mode_switch
);

  localparam logic [9:0] X_LAST    = 10'(H_VALID - 1);
  localparam logic [9:0] Y_LAST    = 10'(V_VALID - 1);
  localparam logic [9:0] X_SIZE    = 10'(H_VALID);
  localparam logic [9:0] Y_SIZE    = 10'(V_VALID);
  localparam logic [9:0] BAR_W     = 10'(H_VALID / 10);
  localparam logic [7:0] HOLD_LAST = 8'(FRAME_HOLD - 1);
  localparam logic [2:0] MODE_LAST = 3'(MODE_NUM - 1);
  localparam logic [2:0] MODE_CNT  = 3'(MODE_NUM);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_PEND  = 2'd1,
    S_BLANK = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [7:0]  frm_cnt_reg, frm_cnt_next;
  logic [2:0]  pat_mode_reg, pat_mode_next;
  logic        mode_switch_reg, mode_switch_next;
  logic [15:0] pix_data_reg, pix_data_next;

  logic        frame_end;
  logic        active;
  logic [9:0]  bar_idx;
  logic [15:0] bar_color;

  assign frame_end = (pix_x == X_LAST) && (pix_y == Y_LAST);
  assign active    = (pix_x < X_SIZE) && (pix_y < Y_SIZE);
  assign bar_idx   = pix_x / BAR_W;

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg       <= S_RUN;
      frm_cnt_reg     <= 8'd0;
      pat_mode_reg    <= 3'd0;
      mode_switch_reg <= 1'b0;
      pix_data_reg    <= 16'h0000;
    end else begin
      state_reg       <= state_next;
      frm_cnt_reg     <= frm_cnt_next;
      pat_mode_reg    <= pat_mode_next;
      mode_switch_reg <= mode_switch_next;
      pix_data_reg    <= pix_data_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    frm_cnt_next     = frm_cnt_reg;
    pat_mode_next    = pat_mode_reg;
    mode_switch_next = 1'b0;
    case (state_reg)
      S_RUN: begin
        if (frame_end) begin
          if ((auto_en && (frm_cnt_reg == HOLD_LAST)) || key_flag) begin
            state_next   = S_BLANK;
            frm_cnt_next = 8'd0;
          end else if (frm_cnt_reg != HOLD_LAST) begin
            frm_cnt_next = frm_cnt_reg + 8'd1;
          end
        end else if (key_flag) begin
          state_next = S_PEND;
        end
      end
      S_PEND: begin
        // A request is already latched, so further keys are dropped.
        if (frame_end) begin
          state_next   = S_BLANK;
          frm_cnt_next = 8'd0;
        end
      end
      S_BLANK: begin
        if (frame_end) begin
          state_next       = S_RUN;
          pat_mode_next    = (pat_mode_reg == MODE_LAST) ? 3'd0 : pat_mode_reg + 3'd1;
          mode_switch_next = 1'b1;
        end
      end
      default: begin
        state_next = S_RUN;
      end
    endcase
  end

  always_comb begin
    case (bar_idx)
      10'd0:   bar_color = 16'hF800;
      10'd1:   bar_color = 16'hFC00;
      10'd2:   bar_color = 16'hFFE0;
      10'd3:   bar_color = 16'h07E0;
      10'd4:   bar_color = 16'h07FF;
      10'd5:   bar_color = 16'h001F;
      10'd6:   bar_color = 16'hF81F;
      10'd7:   bar_color = 16'h0000;
      10'd8:   bar_color = 16'hFFFF;
      10'd9:   bar_color = 16'hD69A;
      default: bar_color = 16'h0000;
    endcase
  end

  // Pixel uses the state of this cycle; the transition cycle's pixel is still drawn.
  always_comb begin
    pix_data_next = 16'h0000;
    if (active && (state_reg != S_BLANK) && (pat_mode_reg < MODE_CNT)) begin
      case (pat_mode_reg)
        3'd0: pix_data_next = bar_color;
        3'd1: pix_data_next = 16'hF800;
        3'd2: pix_data_next = 16'h07E0;
        3'd3: pix_data_next = 16'h001F;
        3'd4: pix_data_next = (pix_x[5] ^ pix_y[5]) ? 16'hFFFF : 16'h0000;
        3'd5: pix_data_next = ((pix_x[5:0] == 6'd0) || (pix_y[5:0] == 6'd0) ||
                               (pix_x == X_LAST) || (pix_y == Y_LAST)) ? 16'hFFFF : 16'h0000;
        default: pix_data_next = 16'h0000;
      endcase
    end
  end

  assign pix_data    = pix_data_reg;
  assign pat_mode    = pat_mode_reg;
  assign mode_switch = mode_switch_reg;

endmodule
